// File: rtl/xnor_prbs_checker.sv
// Self-synchronising checker for XNOR-feedback Fibonacci LFSR bit streams.
// Seeds from the line, confirms sync, then free-runs and counts bit errors.
module xnor_prbs_checker #(
  parameter int WIDTH         = 7,
  parameter int TAP_A         = 6,
  parameter int TAP_B         = 5,
  parameter int LOCK_THRESH   = 16,
  parameter int UNLOCK_THRESH = 4,
  parameter int ERR_CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [1:0] ST_SEED   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int SC_W = $clog2(WIDTH + 1);
  localparam int MC_W = $clog2(LOCK_THRESH + 1);
  localparam int EC_W = $clog2(UNLOCK_THRESH + 1);

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     s_q, s_d;
  logic [SC_W-1:0]      seed_cnt_q, seed_cnt_d;
  logic [MC_W-1:0]      match_cnt_q, match_cnt_d;
  logic [EC_W-1:0]      cons_err_q, cons_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 err_pulse_q, err_pulse_d;

  logic             exp_bit;
  logic [WIDTH-1:0] shift_in;

  assign exp_bit  = ~(s_q[TAP_A] ^ s_q[TAP_B]);
  assign shift_in = {s_q[WIDTH-2:0], in_bit};

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    cons_err_d  = cons_err_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;

    if (in_valid) begin
      case (state_q)
        ST_SEED: begin
          s_d = shift_in;
          if (seed_cnt_q == SC_W'(WIDTH - 1)) begin
            seed_cnt_d = '0;
            // An all-ones seed is the XNOR lockup state; keep seeding.
            if (!(&shift_in)) begin
              state_d     = ST_SYNC;
              match_cnt_d = '0;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + SC_W'(1);
          end
        end

        ST_SYNC: begin
          s_d = shift_in;
          if (in_bit == exp_bit) begin
            match_cnt_d = match_cnt_q + MC_W'(1);
          end else begin
            match_cnt_d = '0;
          end
          if (&shift_in) begin
            state_d     = ST_SEED;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
          end else if ((in_bit == exp_bit) &&
                       (match_cnt_q == MC_W'(LOCK_THRESH - 1))) begin
            state_d    = ST_LOCKED;
            cons_err_d = '0;
          end
        end

        ST_LOCKED: begin
          // Free-run on the local prediction so line errors never propagate.
          s_d = {s_q[WIDTH-2:0], exp_bit};
          if (in_bit != exp_bit) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            if (cons_err_q == EC_W'(UNLOCK_THRESH - 1)) begin
              state_d     = ST_SEED;
              s_d         = '0;
              seed_cnt_d  = '0;
              match_cnt_d = '0;
              cons_err_d  = '0;
            end else begin
              cons_err_d = cons_err_q + EC_W'(1);
            end
          end else begin
            cons_err_d = '0;
          end
        end

        default: begin
          state_d = ST_SEED;
        end
      endcase
    end

    if (clear_cnt) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SEED;
      s_q         <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      cons_err_q  <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      cons_err_q  <= cons_err_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_xnor_prbs_checker.sv
// Bench for xnor_prbs_checker: two instances (16-bit and 3-bit error counters)
// driven by one stream and checked every cycle against a bit-history model.
module tb_xnor_prbs_checker;

  localparam int W  = 7;
  localparam int TA = 6;
  localparam int TB = 5;
  localparam int LT = 16;
  localparam int UT = 4;

  logic clk = 1'b0;
  logic rst, in_valid, in_bit, clear_cnt;
  logic        locked0, pulse0;
  logic [15:0] cnt0;
  logic        locked1, pulse1;
  logic [2:0]  cnt1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xnor_prbs_checker #(.WIDTH(W), .TAP_A(TA), .TAP_B(TB), .LOCK_THRESH(LT),
                      .UNLOCK_THRESH(UT), .ERR_CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .clear_cnt(clear_cnt), .locked(locked0), .err_pulse(pulse0), .err_cnt(cnt0));

  xnor_prbs_checker #(.WIDTH(W), .TAP_A(TA), .TAP_B(TB), .LOCK_THRESH(LT),
                      .UNLOCK_THRESH(UT), .ERR_CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .clear_cnt(clear_cnt), .locked(locked1), .err_pulse(pulse1), .err_cnt(cnt1));

  // Model: hist[id][k] is the bit accepted k positions ago; mode 0/1/2 = seed/sync/locked.
  int m_mode[2], m_seed[2], m_match[2], m_cons[2], m_cnt[2], m_pulse[2], m_max[2];
  bit hist[2][W];
  int g;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_hist(input int id, input bit nb);
    for (int k = W - 1; k > 0; k--) hist[id][k] = hist[id][k-1];
    hist[id][0] = nb;
  endtask

  function automatic bit hist_all_ones(input int id);
    for (int k = 0; k < W; k++) if (!hist[id][k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear(input int id);
    m_mode[id] = 0; m_seed[id] = 0; m_match[id] = 0; m_cons[id] = 0;
    for (int k = 0; k < W; k++) hist[id][k] = 1'b0;
  endtask

  task automatic model_step(input int id);
    bit e;
    m_pulse[id] = 0;
    if (rst) begin
      model_clear(id);
      m_cnt[id] = 0;
      return;
    end
    if (in_valid) begin
      e = !(hist[id][TA] ^ hist[id][TB]);
      if (m_mode[id] == 0) begin
        push_hist(id, in_bit);
        m_seed[id]++;
        if (m_seed[id] == W) begin
          m_seed[id] = 0;
          if (!hist_all_ones(id)) begin m_mode[id] = 1; m_match[id] = 0; end
        end
      end else if (m_mode[id] == 1) begin
        push_hist(id, in_bit);
        m_match[id] = (in_bit == e) ? m_match[id] + 1 : 0;
        if (hist_all_ones(id)) begin
          m_mode[id] = 0; m_seed[id] = 0; m_match[id] = 0;
        end else if (m_match[id] == LT) begin
          m_mode[id] = 2; m_cons[id] = 0;
        end
      end else begin
        push_hist(id, e);
        if (in_bit == e) begin
          m_cons[id] = 0;
        end else begin
          m_pulse[id] = 1;
          if (m_cnt[id] < m_max[id]) m_cnt[id]++;
          m_cons[id]++;
          if (m_cons[id] == UT) model_clear(id);
        end
      end
    end
    if (clear_cnt) m_cnt[id] = 0;
  endtask

  // One clock: drive, model the edge, then compare both DUTs just after it.
  task automatic cyc(input bit r, input bit v, input bit b, input bit c);
    rst = r; in_valid = v; in_bit = b; clear_cnt = c;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("locked0", int'(locked0), int'(m_mode[0] == 2));
    check("pulse0",  int'(pulse0),  m_pulse[0]);
    check("cnt0",    int'(cnt0),    m_cnt[0]);
    check("locked1", int'(locked1), int'(m_mode[1] == 2));
    check("pulse1",  int'(pulse1),  m_pulse[1]);
    check("cnt1",    int'(cnt1),    m_cnt[1]);
  endtask

  // Reference PRBS source x^7+x^6+1 with XNOR feedback.
  task automatic gen_bit(output bit b);
    b = bit'(1 ^ ((g >> 6) & 1) ^ ((g >> 5) & 1));
    g = ((g << 1) | int'(b)) & 127;
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0);
    g = 0;
  endtask

  initial begin
    bit b;
    int acc;
    m_max[0] = 65535;
    m_max[1] = 7;
    for (int id = 0; id < 2; id++) begin model_clear(id); m_cnt[id] = 0; m_pulse[id] = 0; end
    rst = 1; in_valid = 0; in_bit = 0; clear_cnt = 0;

    // Reset, then idle with random data on the line.
    do_reset();
    cyc(1, 0, 0, 0);
    check("rst_locked", int'(locked0), 0);
    check("rst_cnt", int'(cnt0), 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1'($urandom), 0);
    check("idle_locked", int'(locked0), 0);

    // Clean stream, continuous valid: lock lands right after bit 23.
    do_reset();
    for (int i = 1; i <= 500; i++) begin
      gen_bit(b);
      cyc(0, 1, b, 0);
      if (i == 22) check("lock_at22", int'(locked0), 0);
      if (i == 23) check("lock_at23", int'(locked0), 1);
    end
    check("clean_cnt", int'(cnt0), 0);

    // Same stream with gapped valid: lock counts accepted bits, not clocks.
    do_reset();
    acc = 0;
    for (int i = 0; i < 100 && acc < 23; i++) begin
      if (i % 2 == 0) begin
        gen_bit(b);
        cyc(0, 1, b, 0);
        acc++;
        if (acc == 22) check("gap_lock22", int'(locked0), 0);
        if (acc == 23) check("gap_lock23", int'(locked0), 1);
      end else begin
        cyc(0, 0, 1'($urandom), 0);
      end
    end
    check("gap_acc", acc, 23);

    // Isolated single-bit errors while locked.
    for (int i = 0; i < 5; i++) begin gen_bit(b); cyc(0, 1, b, 0); end
    gen_bit(b); cyc(0, 1, ~b, 0);
    check("err1_pulse", int'(pulse0), 1);
    check("err1_cnt", int'(cnt0), 1);
    check("err1_locked", int'(locked0), 1);
    gen_bit(b); cyc(0, 1, b, 0);
    check("err1_pulse_off", int'(pulse0), 0);
    for (int i = 0; i < 8; i++) begin gen_bit(b); cyc(0, 1, b, 0); end
    gen_bit(b); cyc(0, 1, ~b, 0);
    check("err2_cnt", int'(cnt0), 2);
    cyc(1, 1, 0, 0);
    check("midrst_locked", int'(locked0), 0);
    check("midrst_cnt", int'(cnt0), 0);
    check("midrst_pulse", int'(pulse0), 0);

    // Burst of UNLOCK_THRESH errors drops lock; clean stream relocks.
    do_reset();
    for (int i = 0; i < 30; i++) begin gen_bit(b); cyc(0, 1, b, 0); end
    for (int i = 0; i < 4; i++) begin gen_bit(b); cyc(0, 1, ~b, 0); end
    check("burst_cnt", int'(cnt0), 4);
    check("burst_unlock", int'(locked0), 0);
    for (int i = 1; i <= 23; i++) begin
      gen_bit(b);
      cyc(0, 1, b, 0);
      if (i == 22) check("relock22", int'(locked0), 0);
    end
    check("relock23", int'(locked0), 1);
    check("relock_cnt", int'(cnt0), 4);

    // Constant ones never get past seeding.
    do_reset();
    for (int i = 0; i < 200; i++) cyc(0, 1, 1, 0);
    check("ones_locked", int'(locked0), 0);
    check("ones_cnt", int'(cnt0), 0);

    // Mismatch in SYNC after 10 matches restarts the match run.
    do_reset();
    for (int i = 1; i <= 70; i++) begin
      gen_bit(b);
      cyc(0, 1, (i == 18) ? ~b : b, 0);
      if (i == 23) check("sync_miss_nolock", int'(locked0), 0);
    end

    // Narrow counter saturates; clear wins over a same-edge error.
    do_reset();
    for (int i = 0; i < 30; i++) begin gen_bit(b); cyc(0, 1, b, 0); end
    for (int e = 0; e < 10; e++) begin
      gen_bit(b); cyc(0, 1, ~b, 0);
      for (int i = 0; i < 4; i++) begin gen_bit(b); cyc(0, 1, b, 0); end
    end
    check("sat_cnt", int'(cnt1), 7);
    check("sat_locked", int'(locked1), 1);
    gen_bit(b); cyc(0, 1, ~b, 1);
    check("clr_cnt", int'(cnt1), 0);
    check("clr_pulse", int'(pulse1), 1);

    // Random traffic: gapped valid, sparse errors, clears and resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 3) != 0) begin
        gen_bit(b);
        if ($urandom_range(0, 29) == 0) b = ~b;
        cyc(0, 1, b, ($urandom_range(0, 99) == 0));
      end else begin
        cyc(0, 0, 1'($urandom), 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xnor_prbs_checker.md
Name: xnor_prbs_checker

Overview:
Serial PRBS checker for XNOR-feedback Fibonacci LFSR streams. It is the receiving end of the team's XNOR-LFSR pattern generators.
- Self-synchronises to the incoming bit stream.
- Declares lock, then flags and counts bit errors.
- Sits behind serial links and loopbacks in bring-up benches and BIST paths.

Parameters:
WIDTH, 7, LFSR length in bits (≥3).
TAP_A, 6, first feedback tap index (register bit).
TAP_B, 5, second feedback tap index (register bit).
LOCK_THRESH, 16, consecutive matches in SYNC required to assert lock.
UNLOCK_THRESH, 4, consecutive mismatches in LOCKED that drop lock.
ERR_CNT_W, 16, error counter width.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_bit is sampled this edge when high.
in_bit  input  1  received serial data bit.
clear_cnt  input  1  synchronous clear of err_cnt.
locked  output  1  high while in LOCKED state.
err_pulse  output  1  one-cycle flag for a mismatched bit accepted in LOCKED.
err_cnt  output  ERR_CNT_W  saturating count of LOCKED mismatches.

Behaviour:
- Reset: when rst is high at an edge, the following clear; rst overrides all other inputs:
  - state to SEED;
  - shift register s[WIDTH-1:0] to 0;
  - seed, match and consecutive-error counters to 0;
  - locked, err_pulse and err_cnt to 0.
- Reset mid-operation behaves identically; no state survives.
- Accepted bit: in_bit at an edge where in_valid=1 and rst=0.
- When in_valid=0: no state, register or counter changes; err_pulse=0.
- Expected bit: exp = ~(s[TAP_A] ^ s[TAP_B]), taken from the register before the edge.
- Shift: s <= {s[WIDTH-2:0], d}. In SEED and SYNC, d = in_bit. In LOCKED, d = exp, so the register free-runs and errors do not propagate.
- All outputs are registered. Each reflects the bit accepted at edge N immediately after edge N; latency is 1 clock from sampling.
- SEED state:
  - Shift in WIDTH accepted bits, counted by the seed counter.
  - On the WIDTH-th bit, if the resulting register is all-ones (the XNOR lockup state), restart SEED with the seed counter at 0.
  - Otherwise go to SYNC with the match counter at 0.
- SYNC state:
  - exp == in_bit: increment the match counter. On reaching LOCK_THRESH, go to LOCKED; locked=1 after that same edge and the consecutive-error counter is 0.
  - exp != in_bit: match counter to 0 and remain in SYNC; the register still takes in_bit.
  - If the register becomes all-ones, return to SEED.
  - err_cnt and err_pulse are never affected in SEED or SYNC.
- LOCKED state:
  - Match: consecutive-error counter to 0.
  - Mismatch: err_pulse=1 for one cycle; err_cnt increments, saturating at 2^ERR_CNT_W-1 with no wrap; consecutive-error counter increments.
  - When the consecutive-error counter reaches UNLOCK_THRESH: go to SEED on that edge; locked=0 and register/counters are cleared as in reset, except err_cnt, which keeps its value.
  - The error that causes unlock is itself counted and pulsed.
- clear_cnt: err_cnt <= 0, taking priority over a same-edge increment; that error is not counted, but err_pulse still fires. State is unaffected.
- Lock timing with a clean stream: locked rises after accepted bit number WIDTH+LOCK_THRESH (23 with defaults).
- Default polynomial: x^7+x^6+1 with XNOR feedback, period 127. The all-zeros register is a legal state.

Test Plan:
1. Reset, then hold in_valid=0 for 10 cycles -> locked=0, err_pulse=0, err_cnt=0 throughout. Assert rst mid-LOCKED -> all outputs 0 the next cycle.
2. Clean default PRBS from register 0, continuous valid -> locked=1 immediately after the 23rd accepted bit. After 500 bits, err_cnt=0 and err_pulse never asserted. Same stream with in_valid toggling 1/0 -> lock after the 23rd accepted bit, not the 23rd clock.
3. Once locked, invert one bit -> err_pulse high for exactly one cycle after that edge, err_cnt=1, locked stays 1. Invert a second isolated bit 10 bits later -> err_cnt=2.
4. Once locked, invert 4 consecutive bits -> err_cnt=4, locked=0 after the 4th bit. Continue the clean stream -> relock 23 accepted bits later, err_cnt still 4.
5. Feed constant in_bit=1 for 200 bits -> never leaves SEED/SYNC, locked=0, err_cnt=0. Inject a mismatch during SYNC after 10 matches -> lock needs 16 further consecutive matches.
6. ERR_CNT_W=3: inject 10 isolated errors while locked -> err_cnt saturates at 7. Assert clear_cnt on the same edge as an error -> err_cnt=0, err_pulse=1.
